// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, constants and helpers for the UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter sends for a given XOR of the data bits.
    function automatic logic expected_parity(input logic xor_data, input logic par_type);
        expected_parity = (par_type == PAR_ODD) ? ~xor_data : xor_data;
    endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// rtl/uart_rx_data_sampling.sv - three-point oversampling and majority vote of the serial line
module data_sampling
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int CW       = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] edge_cnt_i,
    input  logic          rx_i,
    output logic          sampled_bit_o
);

    localparam logic [CW-1:0] SAMPLE_FIRST  = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SAMPLE_SECOND = CW'(PRESCALE / 2);

    // The first two samples are held; the third is the live line at the
    // decision point, so the vote is ready in that same cycle.
    logic [1:0] samples_q;

    // Capture the line at the first two sample points of every bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samples_q <= {2{IDLE_LEVEL}};
        end else if (edge_cnt_i == SAMPLE_FIRST || edge_cnt_i == SAMPLE_SECOND) begin
            samples_q <= {samples_q[0], rx_i};
        end
    end

    assign sampled_bit_o = maj3(samples_q[1], samples_q[0], rx_i);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver top; UART_RX_SYNC_EN adds a 2-flop input synchronizer
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_in,
    input  logic             Par_en,
    input  logic             Par_type,
    output logic [WIDTH-1:0] P_data,
    output logic             Data_valid,
    output logic             Par_err,
    output logic             Stp_err
);

    localparam int CW = $clog2(PRESCALE);
    localparam int BW = $clog2(WIDTH + 3);

    localparam logic [CW-1:0] EDGE_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] EDGE_DECIDE = CW'(PRESCALE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for an RX line asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {2{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], RX_in};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_in;
`endif

    rx_state_e        state_q;
    logic [CW-1:0]    edge_cnt_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             par_en_q;
    logic             par_type_q;
    logic             par_bad_q;
    logic             vote;
    logic             decide;
    logic             wrap;

    data_sampling #(
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) u_sampling (
        .clk           (clk),
        .rst           (rst),
        .edge_cnt_i    (edge_cnt_q),
        .rx_i          (rx_s),
        .sampled_bit_o (vote)
    );

    assign decide = (edge_cnt_q == EDGE_DECIDE);
    assign wrap   = (edge_cnt_q == EDGE_LAST);

    // Frame FSM with bit timing counters and registered result pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= PAR_EVEN;
            par_bad_q  <= 1'b0;
            P_data     <= '0;
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
        end else begin
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;

            if (state_q != IDLE) begin
                edge_cnt_q <= wrap ? '0 : edge_cnt_q + 1'b1;
                if (wrap) begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    // The falling-edge cycle counts as edge 0 of the start bit.
                    if (rx_s != IDLE_LEVEL) begin
                        state_q    <= START;
                        edge_cnt_q <= CW'(1);
                        bit_cnt_q  <= '0;
                        par_en_q   <= Par_en;
                        par_type_q <= Par_type;
                        par_bad_q  <= 1'b0;
                    end
                end
                START: begin
                    if (decide && vote) begin
                        state_q    <= IDLE;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end else if (wrap) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // Shifting in from the top leaves the first (LSB) bit at bit 0.
                    if (decide) begin
                        shift_q <= {vote, shift_q[WIDTH-1:1]};
                    end
                    if (wrap && bit_cnt_q == BIT_LAST) begin
                        state_q <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decide) begin
                        par_bad_q <= (vote != expected_parity(^shift_q, par_type_q));
                    end
                    if (wrap) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // Leave at the decision point so a start edge late in the
                    // stop bit is not missed.
                    if (decide) begin
                        if (!vote) begin
                            Stp_err <= 1'b1;
                        end else if (!par_bad_q) begin
                            Data_valid <= 1'b1;
                            P_data     <= shift_q;
                        end else begin
                            Par_err <= 1'b1;
                        end
                        state_q    <= IDLE;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int PS    = 8;
    localparam int NLINE = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_in = 1'b1;
    logic       Par_en = 1'b0;
    logic       Par_type = 1'b0;
    logic [7:0] P_data;
    logic       Data_valid;
    logic       Par_err;
    logic       Stp_err;

    logic line_lvl [0:NLINE-1];

    int checks   = 0;
    int failures = 0;
    int dv_cnt, pe_cnt, se_cnt;
    int dv_first, dv_last, pe_first, se_first;

    uart_rx #(
        .WIDTH    (8),
        .PRESCALE (PS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_in      (RX_in),
        .Par_en     (Par_en),
        .Par_type   (Par_type),
        .P_data     (P_data),
        .Data_valid (Data_valid),
        .Par_err    (Par_err),
        .Stp_err    (Stp_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_idle();
        for (int i = 0; i < NLINE; i++) line_lvl[i] = 1'b1;
    endtask

    task automatic put_bit(input int start, input int j, input logic v);
        for (int k = 0; k < PS; k++) line_lvl[start + j * PS + k] = v;
    endtask

    task automatic put_frame(input int start, input logic [7:0] d, input logic pen,
                             input logic pbit, input logic sbit);
        put_bit(start, 0, 1'b0);
        for (int i = 0; i < 8; i++) put_bit(start, i + 1, d[i]);
        if (pen) begin
            put_bit(start, 9, pbit);
            put_bit(start, 10, sbit);
        end else begin
            put_bit(start, 9, sbit);
        end
    endtask

    // Cycle c: outputs sampled at its negedge reflect the decision made in cycle c-1.
    task automatic run_cycles(input int ncyc);
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
        dv_first = -1; dv_last = -1; pe_first = -1; se_first = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (Data_valid) begin
                dv_cnt++;
                if (dv_first < 0) dv_first = c;
                dv_last = c;
            end
            if (Par_err) begin
                pe_cnt++;
                if (pe_first < 0) pe_first = c;
            end
            if (Stp_err) begin
                se_cnt++;
                if (se_first < 0) se_first = c;
            end
            RX_in = line_lvl[c];
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_pdata", P_data, 0);
        check_val("rst_dv", Data_valid, 0);
        check_val("rst_pe", Par_err, 0);
        check_val("rst_se", Stp_err, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, even parity, parity bit 0
        Par_en = 1'b1; Par_type = 1'b0;
        fill_idle(); put_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1);
        run_cycles(100);
        check_val("a5_dv_cnt", dv_cnt, 1);
        check_val("a5_dv_cyc", dv_first, 86);
        check_val("a5_pdata", P_data, 32'hA5);
        check_val("a5_pe_cnt", pe_cnt, 0);
        check_val("a5_se_cnt", se_cnt, 0);

        // 0x3C, no parity
        Par_en = 1'b0;
        fill_idle(); put_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        run_cycles(100);
        check_val("3c_dv_cnt", dv_cnt, 1);
        check_val("3c_dv_cyc", dv_first, 78);
        check_val("3c_pdata", P_data, 32'h3C);

        // 0x01, odd parity, wrong parity bit 1
        Par_en = 1'b1; Par_type = 1'b1;
        fill_idle(); put_frame(0, 8'h01, 1'b1, 1'b1, 1'b1);
        run_cycles(100);
        check_val("perr_pe_cnt", pe_cnt, 1);
        check_val("perr_pe_cyc", pe_first, 86);
        check_val("perr_dv_cnt", dv_cnt, 0);
        check_val("perr_pdata", P_data, 32'h3C);

        // 0x55, no parity, stop bit 0
        Par_en = 1'b0;
        fill_idle(); put_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        run_cycles(100);
        check_val("serr_se_cnt", se_cnt, 1);
        check_val("serr_se_cyc", se_first, 78);
        check_val("serr_dv_cnt", dv_cnt, 0);
        check_val("serr_pdata", P_data, 32'h3C);

        // Parity and stop both wrong: only the stop error is reported
        Par_en = 1'b1; Par_type = 1'b1;
        fill_idle(); put_frame(0, 8'h01, 1'b1, 1'b1, 1'b0);
        run_cycles(100);
        check_val("both_se_cnt", se_cnt, 1);
        check_val("both_pe_cnt", pe_cnt, 0);
        check_val("both_dv_cnt", dv_cnt, 0);

        // Two-cycle start glitch, then a real frame 0x96 at cycle 20
        Par_en = 1'b0;
        fill_idle();
        line_lvl[0] = 1'b0; line_lvl[1] = 1'b0;
        put_frame(20, 8'h96, 1'b0, 1'b0, 1'b1);
        run_cycles(110);
        check_val("glitch_dv_cnt", dv_cnt, 1);
        check_val("glitch_dv_cyc", dv_first, 98);
        check_val("glitch_pdata", P_data, 32'h96);
        check_val("glitch_err", pe_cnt + se_cnt, 0);

        // Single-sample glitches inside data bits are voted out
        fill_idle(); put_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        line_lvl[12] = 1'b0;
        line_lvl[52] = 1'b1;
        run_cycles(100);
        check_val("vote_dv_cnt", dv_cnt, 1);
        check_val("vote_pdata", P_data, 32'h0F);

        // Back-to-back 0x12 / 0x34, even parity, second start at cycle 88
        Par_en = 1'b1; Par_type = 1'b0;
        fill_idle();
        put_frame(0, 8'h12, 1'b1, 1'b0, 1'b1);
        put_frame(88, 8'h34, 1'b1, 1'b1, 1'b1);
        run_cycles(190);
        check_val("b2b_dv_cnt", dv_cnt, 2);
        check_val("b2b_dv_first", dv_first, 86);
        check_val("b2b_dv_last", dv_last, 174);
        check_val("b2b_pdata", P_data, 32'h34);

        // Reset in the middle of the data bits
        fill_idle(); put_frame(0, 8'h77, 1'b1, 1'b0, 1'b1);
        run_cycles(30);
        RX_in = 1'b1;
        rst = 1'b0;
        #1;
        check_val("mrst_pdata", P_data, 0);
        check_val("mrst_dv", Data_valid, 0);
        check_val("mrst_pe", Par_err, 0);
        check_val("mrst_se", Stp_err, 0);
        @(negedge clk);
        rst = 1'b1;
        fill_idle();
        run_cycles(120);
        check_val("mrst_pulses", dv_cnt + pe_cnt + se_cnt, 0);
        check_val("mrst_pdata_after", P_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
